// File: rtl/bcd2binary_seq_if.sv
// Handshake/data bundle for the sequential BCD-to-binary converter.
// The master drives the request and the BCD word; the slave returns the result and status.
interface bcd2binary_seq_if #(
    parameter int unsigned DIGITS = 5,
    parameter int unsigned W      = 17
);
    logic                  START;
    logic [4*DIGITS-1:0]   BCD;
    logic [W-1:0]          BIN;
    logic                  BUSY;
    logic                  DONE;
    logic                  ERR;
    logic                  OVF;

    modport master (
        output START, BCD,
        input  BIN, BUSY, DONE, ERR, OVF
    );

    modport slave (
        input  START, BCD,
        output BIN, BUSY, DONE, ERR, OVF
    );
endinterface

// File: rtl/bcd2binary_seq.sv
// Digit-serial BCD-to-binary converter, MSD first, one digit per clock.
// Build option BCD2BINARY_SAT_EN: saturate BIN to 2^W-1 on overflow instead of wrapping mod 2^W.
module bcd2binary_seq #(
    parameter int unsigned DIGITS = 5,
    parameter int unsigned W      = 17
) (
    input  logic               CLK,
    input  logic               R_N,
    bcd2binary_seq_if.slave    bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned ACC_W = W + 4;
    localparam int unsigned CNT_W = $clog2(DIGITS + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {4'b0000, {W{1'b1}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   sr_q, sr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;
    logic [W-1:0]       bin_q, bin_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_out_q, err_out_d;
    logic               ovf_out_q, ovf_out_d;

    logic [3:0]         digit;
    logic [ACC_W-1:0]   acc_mac;
    logic               acc_over;
    logic [W-1:0]       result;

`ifndef BCD2BINARY_SAT_EN
    // Wrapping accumulator gives the true value mod 2^W independent of the clamp.
    logic [W-1:0]       mod_q, mod_d;
    logic [W-1:0]       mod_mac;
`endif

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        bin_d     = bin_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_out_d = err_out_q;
        ovf_out_d = ovf_out_q;

        digit    = sr_q[BCD_W-1 -: 4];
        acc_mac  = acc_q * ACC_W'(10) + ACC_W'(digit);
        acc_over = (acc_mac > ACC_MAX);
`ifdef BCD2BINARY_SAT_EN
        result   = acc_over ? ACC_MAX[W-1:0] : acc_mac[W-1:0];
`else
        mod_d    = mod_q;
        mod_mac  = W'({4'b0000, mod_q} * ACC_W'(10) + ACC_W'(digit));
        result   = mod_mac;
`endif

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_d = RUN;
                    sr_d    = bus.BCD;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(DIGITS);
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
`ifndef BCD2BINARY_SAT_EN
                    mod_d   = '0;
`endif
                end
            end
            RUN: begin
                sr_d  = sr_q << 4;
                acc_d = acc_over ? ACC_MAX : acc_mac;
                cnt_d = cnt_q - CNT_W'(1);
                err_d = err_q | (digit > 4'd9);
                ovf_d = ovf_q | acc_over;
`ifndef BCD2BINARY_SAT_EN
                mod_d = mod_mac;
`endif
                // Last digit: publish result and status on this same edge.
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    bin_d     = result;
                    err_out_d = err_d;
                    ovf_out_d = ovf_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            bin_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_out_q <= 1'b0;
            ovf_out_q <= 1'b0;
`ifndef BCD2BINARY_SAT_EN
            mod_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            bin_q     <= bin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_out_q <= err_out_d;
            ovf_out_q <= ovf_out_d;
`ifndef BCD2BINARY_SAT_EN
            mod_q     <= mod_d;
`endif
        end
    end

    assign bus.BIN  = bin_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.ERR  = err_out_q;
    assign bus.OVF  = ovf_out_q;

endmodule

// File: tb/tb_bcd2binary_seq.sv
// Self-checking bench for bcd2binary_seq: a 5-digit/17-bit instance and a 3-digit/8-bit
// instance, checked against an arithmetic model of the digit-weighted sum.
module tb_bcd2binary_seq;
`ifdef BCD2BINARY_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic CLK = 1'b0;
    logic R_N;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    bcd2binary_seq_if #(.DIGITS(5), .W(17)) ifa ();
    bcd2binary_seq_if #(.DIGITS(3), .W(8))  ifb ();

    bcd2binary_seq #(.DIGITS(5), .W(17)) dut_a (.CLK(CLK), .R_N(R_N), .bus(ifa));
    bcd2binary_seq #(.DIGITS(3), .W(8))  dut_b (.CLK(CLK), .R_N(R_N), .bus(ifb));

    // Reference: weighted decimal sum with face-value digits; overflow if it exceeds 2^w-1.
    function automatic void model_conv(input logic [19:0] bcd, input int digits, input int w,
                                       output logic [16:0] bin, output logic err,
                                       output logic ovf);
        longint v = 0;
        longint maxv = (longint'(1) << w) - 1;
        err = 1'b0;
        for (int i = digits - 1; i >= 0; i--) begin
            longint dg = longint'((bcd >> (4 * i)) & 20'hF);
            if (dg > 9) err = 1'b1;
            v = v * 10 + dg;
        end
        ovf = (v > maxv);
        if (ovf && SAT) bin = 17'(maxv);
        else            bin = 17'(v % (maxv + 1));
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? ifb.DONE : ifa.DONE;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? ifb.BUSY : ifa.BUSY;
    endfunction

    function automatic logic [19:0] rand_bcd(input int digits);
        logic [19:0] v = '0;
        for (int i = 0; i < digits; i++) begin
            int unsigned nib = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15)
                                                          : $urandom_range(0, 9);
            v = v | (20'(nib) << (4 * i));
        end
        return v;
    endfunction

    // Pulse START once, then wait (bounded) for DONE; returns observations only.
    task automatic run_conv(input bit sel, input logic [19:0] bcd,
                            output logic [16:0] bin, output logic err, output logic ovf,
                            output int lat, output int busy_n, output logic done_after);
        @(negedge CLK);
        if (sel) begin ifb.START = 1'b1; ifb.BCD = bcd[11:0]; end
        else     begin ifa.START = 1'b1; ifa.BCD = bcd;       end
        @(posedge CLK); #1;
        ifa.START = 1'b0;
        ifb.START = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!get_done(sel) && lat < 40) begin
            if (get_busy(sel)) busy_n++;
            @(posedge CLK); #1;
            lat++;
        end
        bin = sel ? 17'(ifb.BIN) : ifa.BIN;
        err = sel ? ifb.ERR : ifa.ERR;
        ovf = sel ? ifb.OVF : ifa.OVF;
        @(posedge CLK); #1;
        done_after = get_done(sel);
    endtask

    task automatic test_reset();
        R_N = 1'b0;
        ifa.START = 1'b0; ifa.BCD = '0;
        ifb.START = 1'b0; ifb.BCD = '0;
        #12;
        n_vec++; if (ifa.BIN !== 17'd0)  begin n_err++; $display("FAIL reset_bin got %h exp 0", ifa.BIN); end
        n_vec++; if (ifa.BUSY !== 1'b0)  begin n_err++; $display("FAIL reset_busy got %b exp 0", ifa.BUSY); end
        n_vec++; if (ifa.DONE !== 1'b0)  begin n_err++; $display("FAIL reset_done got %b exp 0", ifa.DONE); end
        n_vec++; if (ifa.ERR !== 1'b0)   begin n_err++; $display("FAIL reset_err got %b exp 0", ifa.ERR); end
        n_vec++; if (ifa.OVF !== 1'b0)   begin n_err++; $display("FAIL reset_ovf got %b exp 0", ifa.OVF); end
        n_vec++; if (ifb.BIN !== 8'd0)   begin n_err++; $display("FAIL reset_bin_b got %h exp 0", ifb.BIN); end
        @(negedge CLK);
        R_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_vec++; if (ifa.BUSY !== 1'b0 || ifa.DONE !== 1'b0)
            begin n_err++; $display("FAIL idle_quiet got busy=%b done=%b exp 0/0", ifa.BUSY, ifa.DONE); end
    endtask

    task automatic test_directed();
        logic [19:0] t_bcd [5] = '{20'h12345, 20'h99999, 20'h00000, 20'h1A000, 20'h00042};
        logic [16:0] t_bin [5] = '{17'h03039, 17'h1869F, 17'd0, 17'd20000, 17'd42};
        logic        t_err [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [16:0] bin; logic err, ovf, dn; int lat, bn;
        for (int i = 0; i < 5; i++) begin
            run_conv(1'b0, t_bcd[i], bin, err, ovf, lat, bn, dn);
            n_vec++; if (lat !== 5) begin n_err++; $display("FAIL dir_latency[%0d] got %0d exp 5", i, lat); end
            n_vec++; if (bn !== 5)  begin n_err++; $display("FAIL dir_busy_cycles[%0d] got %0d exp 5", i, bn); end
            n_vec++; if (bin !== t_bin[i]) begin n_err++; $display("FAIL dir_bin[%0d] got %h exp %h", i, bin, t_bin[i]); end
            n_vec++; if (err !== t_err[i]) begin n_err++; $display("FAIL dir_err[%0d] got %b exp %b", i, err, t_err[i]); end
            n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL dir_ovf[%0d] got %b exp 0", i, ovf); end
            n_vec++; if (dn !== 1'b0)  begin n_err++; $display("FAIL dir_done_pulse[%0d] got %b exp 0", i, dn); end
        end
    endtask

    task automatic test_random();
        logic [16:0] bin, m_bin; logic err, ovf, dn, m_err, m_ovf; int lat, bn;
        logic [19:0] bcd;
        for (int i = 0; i < 40; i++) begin
            bcd = rand_bcd(5);
            model_conv(bcd, 5, 17, m_bin, m_err, m_ovf);
            run_conv(1'b0, bcd, bin, err, ovf, lat, bn, dn);
            n_vec++;
            if (bin !== m_bin || err !== m_err || ovf !== m_ovf || lat !== 5) begin
                n_err++;
                $display("FAIL rand bcd=%h got bin=%h err=%b ovf=%b lat=%0d exp bin=%h err=%b ovf=%b lat=5",
                         bcd, bin, err, ovf, lat, m_bin, m_err, m_ovf);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int d1 = -1, d2 = -1, nd = 0;
        logic [16:0] bin5 = '0, bin11 = '0;
        logic busy6 = 1'b0;
        @(negedge CLK);
        ifa.BCD = 20'h12345; ifa.START = 1'b1;
        @(posedge CLK); #1;
        ifa.START = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c - 1 == 2 || c - 1 == 4) begin ifa.START = 1'b1; ifa.BCD = 20'h55555; end
            if (c - 1 == 3 || c - 1 == 6) ifa.START = 1'b0;
            @(posedge CLK); #1;
            if (ifa.DONE) begin
                nd++;
                if (d1 < 0) begin d1 = c; bin5 = ifa.BIN; end
                else        begin d2 = c; bin11 = ifa.BIN; end
            end
            if (c == 6) busy6 = ifa.BUSY;
        end
        n_vec++; if (nd !== 2)  begin n_err++; $display("FAIL busy_done_count got %0d exp 2", nd); end
        n_vec++; if (d1 !== 5)  begin n_err++; $display("FAIL busy_first_done got %0d exp 5", d1); end
        n_vec++; if (bin5 !== 17'h03039) begin n_err++; $display("FAIL busy_ignored_bin got %h exp 03039", bin5); end
        n_vec++; if (busy6 !== 1'b1) begin n_err++; $display("FAIL done_cycle_start_busy got %b exp 1", busy6); end
        n_vec++; if (d2 !== 11) begin n_err++; $display("FAIL done_cycle_start_done got %0d exp 11", d2); end
        n_vec++; if (bin11 !== 17'd55555) begin n_err++; $display("FAIL done_cycle_start_bin got %h exp %h", bin11, 17'd55555); end
    endtask

    task automatic test_back_to_back();
        int nd = 0;
        @(negedge CLK);
        ifa.BCD = 20'h00042; ifa.START = 1'b1;
        @(posedge CLK); #1;
        for (int c = 1; c <= 20; c++) begin
            if (c - 1 == 15) ifa.START = 1'b0;
            @(posedge CLK); #1;
            if (ifa.DONE) begin
                n_vec++;
                if (c !== 5 + 6 * nd || ifa.BIN !== 17'd42) begin
                    n_err++;
                    $display("FAIL b2b_done[%0d] got cycle=%0d bin=%h exp cycle=%0d bin=%h",
                             nd, c, ifa.BIN, 5 + 6 * nd, 17'd42);
                end
                nd++;
            end
        end
        n_vec++; if (nd !== 3) begin n_err++; $display("FAIL b2b_count got %0d exp 3", nd); end
    endtask

    task automatic test_reset_mid_run();
        logic [16:0] bin, m_bin; logic err, ovf, dn, m_err, m_ovf; int lat, bn, nd = 0;
        model_conv(20'hFA000, 5, 17, m_bin, m_err, m_ovf);
        run_conv(1'b0, 20'hFA000, bin, err, ovf, lat, bn, dn);
        n_vec++;
        if (bin !== m_bin || err !== 1'b1 || ovf !== 1'b1) begin
            n_err++;
            $display("FAIL pre_abort got bin=%h err=%b ovf=%b exp bin=%h err=1 ovf=1", bin, err, ovf, m_bin);
        end
        @(negedge CLK);
        ifa.BCD = 20'h12345; ifa.START = 1'b1;
        @(posedge CLK); #1;
        ifa.START = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_vec++; if (ifa.ERR !== 1'b1 || ifa.OVF !== 1'b1 || ifa.BUSY !== 1'b1)
            begin n_err++; $display("FAIL status_hold got err=%b ovf=%b busy=%b exp 1/1/1", ifa.ERR, ifa.OVF, ifa.BUSY); end
        @(posedge CLK); #2;
        R_N = 1'b0;
        #1;
        n_vec++;
        if (ifa.BUSY !== 1'b0 || ifa.DONE !== 1'b0 || ifa.BIN !== 17'd0 || ifa.ERR !== 1'b0 || ifa.OVF !== 1'b0) begin
            n_err++;
            $display("FAIL abort_outputs got busy=%b done=%b bin=%h err=%b ovf=%b exp all 0",
                     ifa.BUSY, ifa.DONE, ifa.BIN, ifa.ERR, ifa.OVF);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        R_N = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge CLK); #1;
            if (ifa.DONE || ifa.BUSY) nd++;
        end
        n_vec++; if (nd !== 0) begin n_err++; $display("FAIL abort_no_done got %0d active cycles exp 0", nd); end
        run_conv(1'b0, 20'h00042, bin, err, ovf, lat, bn, dn);
        n_vec++; if (bin !== 17'd42 || lat !== 5)
            begin n_err++; $display("FAIL post_abort got bin=%h lat=%0d exp 2a/5", bin, lat); end
    endtask

    task automatic test_small_width();
        logic [16:0] bin, m_bin; logic err, ovf, dn, m_err, m_ovf; int lat, bn;
        logic [16:0] exp300 = SAT ? 17'd255 : 17'd44;
        logic [19:0] bcd;
        run_conv(1'b1, 20'h300, bin, err, ovf, lat, bn, dn);
        n_vec++; if (bin !== exp300 || ovf !== 1'b1)
            begin n_err++; $display("FAIL small_300 got bin=%0d ovf=%b exp bin=%0d ovf=1", bin, ovf, exp300); end
        n_vec++; if (lat !== 3 || dn !== 1'b0)
            begin n_err++; $display("FAIL small_latency got lat=%0d done_after=%b exp 3/0", lat, dn); end
        run_conv(1'b1, 20'h255, bin, err, ovf, lat, bn, dn);
        n_vec++; if (bin !== 17'd255 || ovf !== 1'b0 || err !== 1'b0)
            begin n_err++; $display("FAIL small_255 got bin=%0d ovf=%b err=%b exp 255/0/0", bin, ovf, err); end
        for (int i = 0; i < 15; i++) begin
            bcd = rand_bcd(3);
            model_conv(bcd, 3, 8, m_bin, m_err, m_ovf);
            run_conv(1'b1, bcd, bin, err, ovf, lat, bn, dn);
            n_vec++;
            if (bin !== m_bin || err !== m_err || ovf !== m_ovf) begin
                n_err++;
                $display("FAIL small_rand bcd=%h got bin=%0d err=%b ovf=%b exp bin=%0d err=%b ovf=%b",
                         bcd[11:0], bin, err, ovf, m_bin, m_err, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_small_width();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
